// File: rtl/seg_scan_encoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus and presents each full frame on a valid/ready port.
// Optional macro SEG_ALT_GLYPH_EN adds alternate glyphs 1F->6, 72->7, 73->9.
module seg_scan_encoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    input  logic                  frame_ready,
    input  logic                  overflow_clr,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid,
    output logic                  overflow
);

    localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

    logic [6:0]          seg_m_q, seg_s_q;
    logic [DIGITS-1:0]   an_m_q, an_s_q;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          pat_q, pat_d;
    logic [DIGITS-1:0]   strobe_q, strobe_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [4*DIGITS-1:0] asm_bcd_q, asm_bcd_d;
    logic [DIGITS-1:0]   asm_err_q, asm_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                frame_valid_q, frame_valid_d;
    logic                overflow_q, overflow_d;

    logic                an_onehot;
    logic [IDX_W-1:0]    an_idx;
    logic                capture;
    logic [3:0]          enc_bcd;
    logic                enc_err;
    logic                frame_complete;
    logic                load;
    logic                drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_q       <= '0;
            seg_s_q       <= '0;
            an_m_q        <= '0;
            an_s_q        <= '0;
            state_q       <= S_WAIT;
            idx_q         <= '0;
            pat_q         <= '0;
            strobe_q      <= '0;
            cnt_q         <= '0;
            asm_bcd_q     <= '0;
            asm_err_q     <= '0;
            seen_q        <= '0;
            bcd_q         <= '0;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            seg_m_q       <= seg_in;
            seg_s_q       <= seg_m_q;
            an_m_q        <= an_in;
            an_s_q        <= an_m_q;
            state_q       <= state_d;
            idx_q         <= idx_d;
            pat_q         <= pat_d;
            strobe_q      <= strobe_d;
            cnt_q         <= cnt_d;
            asm_bcd_q     <= asm_bcd_d;
            asm_err_q     <= asm_err_d;
            seen_q        <= seen_d;
            bcd_q         <= bcd_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        an_onehot = $onehot(an_s_q);
        an_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_s_q[i]) an_idx = IDX_W'(i);
        end
    end

    // Blank (all segments off) is a legal digit reported as nibble A.
    always_comb begin
        enc_bcd = 4'hF;
        enc_err = 1'b1;
        case (pat_q)
            7'h7E: begin enc_bcd = 4'h0; enc_err = 1'b0; end
            7'h30: begin enc_bcd = 4'h1; enc_err = 1'b0; end
            7'h6D: begin enc_bcd = 4'h2; enc_err = 1'b0; end
            7'h79: begin enc_bcd = 4'h3; enc_err = 1'b0; end
            7'h33: begin enc_bcd = 4'h4; enc_err = 1'b0; end
            7'h5B: begin enc_bcd = 4'h5; enc_err = 1'b0; end
            7'h5F: begin enc_bcd = 4'h6; enc_err = 1'b0; end
            7'h70: begin enc_bcd = 4'h7; enc_err = 1'b0; end
            7'h7F: begin enc_bcd = 4'h8; enc_err = 1'b0; end
            7'h7B: begin enc_bcd = 4'h9; enc_err = 1'b0; end
            7'h00: begin enc_bcd = 4'hA; enc_err = 1'b0; end
`ifdef SEG_ALT_GLYPH_EN
            7'h1F: begin enc_bcd = 4'h6; enc_err = 1'b0; end
            7'h72: begin enc_bcd = 4'h7; enc_err = 1'b0; end
            7'h73: begin enc_bcd = 4'h9; enc_err = 1'b0; end
`endif
            default: begin enc_bcd = 4'hF; enc_err = 1'b1; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        strobe_d = strobe_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (an_onehot) begin
                    idx_d    = an_idx;
                    pat_d    = seg_s_q;
                    strobe_d = an_s_q;
                    cnt_d    = 8'd1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (an_s_q == strobe_q && seg_s_q == pat_q) begin
                    if (cnt_q + 8'd1 == STABLE_N) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (an_onehot) begin
                    idx_d    = an_idx;
                    pat_d    = seg_s_q;
                    strobe_d = an_s_q;
                    cnt_d    = 8'd1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            // One capture per strobe period: wait for the strobe to move on.
            S_HOLD: begin
                if (an_s_q != strobe_q) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        frame_complete = &seen_q;
        load           = frame_complete && (!frame_valid_q || frame_ready);
        drop           = frame_complete && !load;

        asm_bcd_d = asm_bcd_q;
        asm_err_d = asm_err_q;
        seen_d    = frame_complete ? '0 : seen_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && idx_q == IDX_W'(i)) begin
                asm_bcd_d[4*i +: 4] = enc_bcd;
                asm_err_d[i]        = enc_err;
                seen_d[i]           = 1'b1;
            end
        end

        bcd_d = load ? asm_bcd_q : bcd_q;
        err_d = load ? asm_err_q : err_q;

        if (load)                              frame_valid_d = 1'b1;
        else if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
        else                                   frame_valid_d = frame_valid_q;

        if (drop)              overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
        else                   overflow_d = overflow_q;
    end

    assign bcd_out     = bcd_q;
    assign err_out     = err_q;
    assign frame_valid = frame_valid_q;
    assign overflow    = overflow_q;

endmodule
